// File: rtl/encoder_pulse_t.sv
// Race-logic pulse encoder: turns a thermometer word into a single line pulse
// whose delay from frame start equals the number of cleared upper bits.
module encoder_pulse_t #(
   parameter int unsigned MAX_VALUE = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [MAX_VALUE-1:0] incoming_value,
   input  logic                 incoming_valid,
   output logic                 incoming_ready,
   output logic                 incoming_code_error,
   output logic                 outgoing_frame_start,
   output logic                 outgoing_busy,
   output logic                 outgoing_line
);

   localparam int unsigned CNT_W = $clog2(MAX_VALUE + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_VALUE);
   localparam logic [MAX_VALUE-1:0] ALL_ONES = '1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] k_reg;
   logic [CNT_W-1:0] top_len;
   logic [CNT_W-1:0] dec_k;
   logic             dec_legal;
   logic             at_last;
   logic             transfer;

   // Delay depends only on the most significant set bit; zero decodes to "no spike".
   always_comb begin
      top_len = '0;
      for (int unsigned i = 0; i < MAX_VALUE; i++) begin
         if (incoming_value[i]) top_len = CNT_W'(i + 1);
      end
      dec_k     = LAST - top_len;
      dec_legal = (incoming_value == (ALL_ONES >> dec_k));
   end

   assign at_last        = (state == RUN) && (count == LAST);
   assign incoming_ready = (state == IDLE) || at_last;
   assign transfer       = incoming_valid && incoming_ready;
   assign count_nxt      = count + CNT_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state                <= IDLE;
         count                <= '0;
         k_reg                <= LAST;
         outgoing_line        <= 1'b0;
         outgoing_frame_start <= 1'b0;
         outgoing_busy        <= 1'b0;
         incoming_code_error  <= 1'b0;
      end else begin
         outgoing_frame_start <= 1'b0;
         incoming_code_error  <= 1'b0;
         if (transfer) begin
            // Also covers the back-to-back case on the last frame cycle.
            state                <= RUN;
            count                <= '0;
            k_reg                <= dec_k;
            outgoing_line        <= (dec_k == '0);
            outgoing_frame_start <= 1'b1;
            outgoing_busy        <= 1'b1;
            incoming_code_error  <= ~dec_legal;
         end else if (state == RUN) begin
            if (at_last) begin
               state         <= IDLE;
               count         <= '0;
               outgoing_busy <= 1'b0;
               outgoing_line <= 1'b0;
            end else begin
               count         <= count_nxt;
               outgoing_line <= (count_nxt == k_reg) && (k_reg != LAST);
            end
         end
      end
   end

endmodule

// File: tb/tb_encoder_pulse_t.sv
// Bench for encoder_pulse_t: directed test-plan sequences plus random traffic,
// checked against a frame-schedule model and a pulse-time decoder.
module tb_encoder_pulse_t;

   localparam int MAXV = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [MAXV-1:0] incoming_value = '0;
   logic            incoming_valid = 1'b0;
   logic            incoming_ready;
   logic            incoming_code_error;
   logic            outgoing_frame_start;
   logic            outgoing_busy;
   logic            outgoing_line;

   encoder_pulse_t #(.MAX_VALUE(MAXV)) dut (
      .clock               (clock),
      .reset               (reset),
      .incoming_value      (incoming_value),
      .incoming_valid      (incoming_valid),
      .incoming_ready      (incoming_ready),
      .incoming_code_error (incoming_code_error),
      .outgoing_frame_start(outgoing_frame_start),
      .outgoing_busy       (outgoing_busy),
      .outgoing_line       (outgoing_line)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: position within the current frame (-1 when idle) plus frame facts.
   int   m_pos = -1;
   int   m_k   = MAXV;
   logic m_err = 1'b0;
   logic m_armed = 1'b0;

   // Decoder side: words in flight and the word of the frame currently on the line.
   logic [MAXV-1:0] sent_q[$];
   logic [MAXV-1:0] cur_word;
   int   cyc    = 0;
   int   fs_cyc = 0;

   function automatic int bit_len(input logic [MAXV-1:0] w);
      int n = 0;
      while (w != '0) begin
         w = w >> 1;
         n++;
      end
      return n;
   endfunction

   function automatic logic is_legal(input logic [MAXV-1:0] w);
      int n = bit_len(w);
      return w == MAXV'((9'd1 << n) - 9'd1);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [MAXV-1:0] obs, input logic [MAXV-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: check current outputs, drive inputs for the next edge, advance model.
   task automatic step(input logic v, input logic [MAXV-1:0] val, input logic rst);
      logic exp_ready;
      logic [MAXV-1:0] ones;
      @(negedge clock);
      exp_ready = (m_pos < 0) || (m_pos == MAXV);
      if (m_armed) begin
         chk("ready", incoming_ready, exp_ready);
         chk("busy", outgoing_busy, m_pos >= 0);
         chk("frame_start", outgoing_frame_start, m_pos == 0);
         chk("line", outgoing_line, (m_pos >= 0) && (m_pos == m_k) && (m_k < MAXV));
         chk("code_error", incoming_code_error, m_err);
         if (outgoing_frame_start) begin
            fs_cyc = cyc;
            cur_word = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
         end
         if (outgoing_line && is_legal(cur_word)) begin
            ones = '1;
            chk_word("decoded_word", ones >> (cyc - fs_cyc), cur_word);
         end
      end
      reset = rst;
      incoming_valid = v;
      incoming_value = val;
      if (rst) begin
         m_pos = -1;
         m_err = 1'b0;
         m_armed = 1'b1;
         sent_q.delete();
      end else if (v && exp_ready) begin
         m_pos = 0;
         m_k   = MAXV - bit_len(val);
         m_err = ~is_legal(val);
         sent_q.push_back(val);
      end else begin
         m_err = 1'b0;
         if (m_pos == MAXV) m_pos = -1;
         else if (m_pos >= 0) m_pos++;
      end
      cyc++;
      @(posedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   initial begin
      logic [MAXV-1:0] rv;
      logic [MAXV-1:0] ones;
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      idle(2);

      step(1'b1, 8'hFF, 1'b0);
      idle(11);
      step(1'b1, 8'h07, 1'b0);
      idle(11);
      step(1'b1, 8'h00, 1'b0);
      idle(11);
      step(1'b1, 8'h29, 1'b0);
      idle(11);

      // Valid held high across the frame boundary.
      step(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, 8'h0F, 1'b0);
      idle(12);

      // Abort mid-frame in frame cycle 3.
      step(1'b1, 8'h01, 1'b0);
      idle(3);
      step(1'b0, '0, 1'b1);
      idle(10);

      for (int i = 0; i < 600; i++) begin
         ones = '1;
         if ($urandom_range(0, 1) == 0) rv = ones >> $urandom_range(0, MAXV);
         else rv = MAXV'($urandom);
         step(($urandom_range(0, 3) != 0), rv, ($urandom_range(0, 80) == 0));
      end
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/encoder_pulse_t.md
Name: encoder_pulse_t

Overview:
Temporal (race-logic) pulse encoder; the transmit end of the pulse-time code consumed by the pulse decoder.
- Accepts a MAX_VALUE-bit thermometer word over a valid/ready handshake.
- Emits a frame of MAX_VALUE+1 cycles on a single line.
- The line carries one single-cycle high pulse at a delay equal to the number of cleared upper bits.
- A downstream decoder restarted at frame start recovers the original word.

Parameters:
- MAX_VALUE, 8, thermometer code width; also the largest finite delay in cycles.
- CNT_W, $clog2(MAX_VALUE+1), frame cycle counter width (derived, not overridden).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- incoming_value  input  MAX_VALUE  thermometer word; the valid form is all-ones >> k.
- incoming_valid  input  1  incoming_value is presented.
- incoming_ready  output  1  encoder can accept a word this cycle.
- incoming_code_error  output  1  one-cycle flag: the accepted word was not a legal thermometer code.
- outgoing_frame_start  output  1  high in the first cycle of each frame.
- outgoing_busy  output  1  a frame is in progress.
- outgoing_line  output  1  pulse line; high for exactly one cycle at frame cycle k.

Behaviour:
- Reset is synchronous and active-high; it is sampled only on the clock posedge. Reset values:
  - state = IDLE
  - frame counter = 0
  - outgoing_line = 0
  - outgoing_frame_start = 0
  - outgoing_busy = 0
  - incoming_code_error = 0
  - incoming_ready = 1 (the cycle after reset)
- Reset asserted mid-frame aborts the frame: next cycle the line is 0, busy is 0 and ready is 1. No pulse is emitted for the aborted frame.
- Delay decode: k = MAX_VALUE - (index of highest set bit + 1).
  - Decode depends only on the MSB-most set bit.
  - incoming_value == 0 gives k = MAX_VALUE, meaning "no spike".
- Legality: the word is legal iff it equals {MAX_VALUE{1'b1}} >> k.
  - On an illegal word, incoming_code_error pulses for one cycle, coincident with outgoing_frame_start.
  - The frame still runs using the k decoded above.
- Handshake: a transfer occurs on a posedge where incoming_valid & incoming_ready.
  - incoming_value is captured on that edge.
  - incoming_value is ignored when no transfer occurs.
- incoming_ready is high when:
  - state == IDLE, or
  - state == RUN and frame counter == MAX_VALUE (last frame cycle).
- State machine (two states):
  - IDLE -> RUN on a transfer; counter <= 0.
  - RUN, counter < MAX_VALUE: counter increments.
  - RUN, counter == MAX_VALUE, with a transfer: stays RUN, counter <= 0, new k loaded. Back-to-back frames have no gap.
  - RUN, counter == MAX_VALUE, no transfer: goes to IDLE.
- Frame timing: for frame cycle i = 0..MAX_VALUE, starting the cycle after the transfer edge:
  - outgoing_line = (i == k), registered. A line pulse therefore appears 1+k cycles after the accepting edge.
  - outgoing_frame_start = (i == 0).
  - outgoing_busy = 1 throughout.
- k = MAX_VALUE produces no pulse; the line stays low for all MAX_VALUE+1 frame cycles.
- At most one pulse per frame; the line is never high in IDLE.
- Throughput: one word per MAX_VALUE+1 cycles when valid is held high.
- incoming_valid asserted while ready is low is neither captured nor dropped-with-error; upstream holds it until ready.
- All outputs are registered, or derived solely from registered state (incoming_ready). There is no combinational path from any input to any output.

Test Plan:
- Reset, then incoming_value=8'b1111_1111 valid for one cycle -> next cycle frame_start=1 and line=1 (k=0); line low for cycles 1..8; busy low after 9 cycles; code_error never set.
- incoming_value=8'b0000_0111 (k=5) -> line high only in frame cycle 5, i.e. 6 cycles after the accept edge; decoder reset at frame_start then reads 8'b0000_0111.
- incoming_value=8'b0000_0000 -> 9-cycle frame with line low throughout; busy high 9 cycles; ready high again in frame cycle 8.
- incoming_value=8'b0010_1001 (illegal, highest bit 5, k=2) -> code_error=1 with frame_start; line pulse in frame cycle 2.
- Valid held high with words 8'hFF then 8'h0F -> second accept in frame cycle 8 of the first frame; second frame_start the very next cycle; pulses at absolute frame cycles 0 and 9+4=13.
- incoming_value=8'h01 (k=7) accepted, reset asserted in frame cycle 3 -> next cycle line=0, busy=0, ready=1; no pulse appears at cycle 7.
